// File: rtl/banked_imem_server.sv
// banked_imem_server: multi-core instruction fetch server over interleaved RAM banks
// with a per-bank round-robin arbiter, one-cycle registered responses and a loader write port.
module banked_imem_server #(
  parameter int nCPUs  = 3,
  parameter int nBANKs = 4,
  parameter int SIZE   = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [nCPUs-1:0]       req_i,
  input  logic [nCPUs-1:0][31:0] addr_i,
  output logic [nCPUs-1:0]       gnt_o,
  output logic [nCPUs-1:0]       rsp_vld_o,
  output logic [nCPUs-1:0][31:0] rsp_data_o,
  input  logic                   wr_en_i,
  input  logic [31:0]            wr_addr_i,
  input  logic [31:0]            wr_data_i
);
  localparam int BW    = $clog2(nBANKs);
  localparam int BI    = BW > 0 ? BW : 1;
  localparam int DEPTH = SIZE / nBANKs;
  localparam int RW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int PW    = nCPUs > 1 ? $clog2(nCPUs) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

`ifndef SYNTHESIS
  if ((nBANKs & (nBANKs - 1)) != 0) begin : g_bad_banks
    $fatal(1, "nBANKs must be a power of 2");
  end
  if (SIZE % nBANKs != 0) begin : g_bad_size
    $fatal(1, "SIZE must be divisible by nBANKs");
  end
`endif

  logic [31:0]             mem_q [nBANKs][DEPTH];
  logic [PW-1:0]           ptr_q [nBANKs];
  logic [PW-1:0]           ptr_d [nBANKs];
  logic [nCPUs-1:0]        gnt_d;
  logic [nCPUs-1:0]        rsp_vld_q;
  logic [nCPUs-1:0][31:0]  rsp_data_q;
  logic [nCPUs-1:0][31:0]  rdata;
  logic [nCPUs-1:0][BI-1:0] bank;
  logic [nCPUs-1:0][RW-1:0] row;
  logic [nCPUs-1:0]        in_rng;
  logic [BI-1:0]           w_bank;
  logic [RW-1:0]           w_row;
  logic                    w_in_rng;
  logic                    found;
  int                      idx;

  always_comb begin
    for (int j = 0; j < nCPUs; j++) begin
      bank[j]   = BI'(addr_i[j] & 32'(nBANKs - 1));
      row[j]    = RW'(addr_i[j] >> BW);
      in_rng[j] = (addr_i[j] >> BW) < 32'(DEPTH);
      rdata[j]  = in_rng[j] ? mem_q[bank[j]][row[j]] : NOP;
    end
    w_bank   = BI'(wr_addr_i & 32'(nBANKs - 1));
    w_row    = RW'(wr_addr_i >> BW);
    w_in_rng = (wr_addr_i >> BW) < 32'(DEPTH);
  end

  // A bank being written this cycle grants nobody, so reads never race writes.
  always_comb begin
    gnt_d = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int b = 0; b < nBANKs; b++) begin
      found = 1'b0;
      for (int k = 0; k < nCPUs; k++) begin
        idx = (int'(ptr_q[b]) + k) % nCPUs;
        if (rst_ni && !(wr_en_i && int'(w_bank) == b) && !found &&
            req_i[idx] && int'(bank[idx]) == b) begin
          found      = 1'b1;
          gnt_d[idx] = 1'b1;
          ptr_d[b]   = PW'((idx + 1) % nCPUs);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      ptr_q      <= '{default: '0};
    end else begin
      rsp_vld_q <= gnt_d;
      ptr_q     <= ptr_d;
      for (int j = 0; j < nCPUs; j++)
        if (gnt_d[j]) rsp_data_q[j] <= rdata[j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && w_in_rng) mem_q[w_bank][w_row] <= wr_data_i;
  end

  assign gnt_o      = gnt_d;
  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_data_o = rsp_data_q;
endmodule

// File: doc/banked_imem_server.md
# banked_imem_server

Responder side of the cluster's shared instruction-fetch interface. Serves word-fetch requests from nCPUs cores out of nBANKs interleaved, synchronously-read instruction RAM banks. Each bank has an independent round-robin arbiter; a granted fetch returns registered data one cycle later. It includes a write port used by the program loader before or between runs.

## Interface
- nCPUs, 3, number of requesting cores
- nBANKs, 4, number of interleaved banks, power of 2
- SIZE, 64, total memory depth in 32-bit words, divisible by nBANKs
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  [nCPUs-1:0]  per-core fetch request, held until granted
- addr  in  [nCPUs-1:0][31:0]  per-core word address, stable while req high
- gnt  out  [nCPUs-1:0]  combinational acceptance of req this cycle
- rsp_vld  out  [nCPUs-1:0]  registered, response data valid
- rsp_data  out  [nCPUs-1:0][31:0]  registered fetched word
- wr_en  in  1  loader write strobe
- wr_addr  in  [31:0]  loader word address
- wr_data  in  [31:0]  loader write data

## Operation
- BANK_ADDR_W = $clog2(nBANKs); DEPTH = SIZE/nBANKs.
- Address split: bank = addr[BANK_ADDR_W-1:0]; row = addr[31:BANK_ADDR_W].
- A row >= DEPTH is out of range: it is arbitrated normally and returns 32'h0000_0013, the RV32I NOP. Out-of-range writes are ignored.
- Per-bank requesters: core j is a requester of bank b when req[j] is high and bank(addr[j]) == b.
- Per-bank arbiter: one priority pointer ptr[b] in 0..nCPUs-1, reset to 0.
  - The grant goes to the first requester at or after ptr[b], searching circularly.
  - On a grant to core j, ptr[b] <= (j+1) mod nCPUs. With no grant, ptr[b] is unchanged.
- Write priority: if wr_en is high, the bank selected by wr_addr grants no core that cycle. Its ptr is unchanged and the write occurs at the clock edge.
- At most one grant per bank per cycle. A single core is granted at most once per cycle.
- Memory contents are not reset. Reading a never-written word returns X in simulation; benches always load the memory first.
- Parameter checks are made at elaboration, outside SYNTHESIS: nBANKs must be a power of 2 and SIZE must be divisible by nBANKs. A violation is $fatal.

## Timing
- gnt is combinational from req, addr, wr_en, wr_addr and ptr. It has no registered path.
- Fetch latency is 1 cycle. If gnt[j]=1 in cycle t, then in cycle t+1 rsp_vld[j]=1 and rsp_data[j]=mem[addr_t].
- If gnt[j]=0, rsp_vld[j] is 0 the next cycle and rsp_data[j] holds its last value.
- Back-to-back: a core may present a new address in cycle t+1. It can be granted every cycle when there is no conflict.
- A write at edge t followed by a read of the same word granted in cycle t+1 returns the new data. Same-cycle conflicts cannot occur because of write priority.
- Reset asserted (rst=0), including mid-operation:
  - rsp_vld = 0, rsp_data = 0 and every ptr = 0, asynchronously.
  - gnt is forced to 0 while rst is low.
  - Fetches in flight are dropped.
- First grants are possible in the first cycle after rst deasserts.

## Test plan
- Reset: drive rst=0 mid-stream with req=3'b111. Required: rsp_vld=0, rsp_data=0 and gnt=0 immediately. After release, ptr behaves as 0, so a 3-way conflict grants core 0 first.
- Load and fetch: write mem[k]=32'h1000+k for k=0..63, then core 0 requests addr 5. Required: gnt[0]=1 in the same cycle; next cycle rsp_vld[0]=1 and rsp_data[0]=32'h1005.
- Bank conflict and fairness: cores 0/1/2 hold addr 1/5/9 (all bank 1). Required: grants go to core 0, 1, 2 in three consecutive cycles, returning 32'h1001, 32'h1005, 32'h1009. A further 3-way conflict restarts at core 0.
- No conflict: cores 0/1/2 request addr 0/1/2 in the same cycle. Required: gnt=3'b111; next cycle rsp_vld=3'b111 with data 32'h1000, 32'h1001, 32'h1002.
- Write priority: wr_en with wr_addr=4 and wr_data=32'hDEAD_BEEF while core 0 requests addr 4. Required: gnt[0]=0 in that cycle; granted the next cycle; rsp_data[0]=32'hDEAD_BEEF the cycle after.
- Out of range: core 1 requests addr 64. Required: granted, then rsp_data[1]=32'h0000_0013. A write to addr 70 leaves all words unchanged.
